dispatch_queue: RTL and testbench

Parametrised, N-wide in-order dispatch buffer between rename and issue/ROB enqueue. It accepts up to WIDTH renamed micro-ops per cycle into a circular queue and presents up to WIDTH of them to issue. Each presented lane is stamped with a ROB index and wrap flag, gated by ROB free space and ROB state. A redirect flush empties the queue in one cycle.

---
 rtl/dispatch_queue.sv | 134 +++++++++++++
 tb/tb_dispatch_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// N-wide in-order dispatch buffer between rename and issue/ROB enqueue.
// Optional same-cycle bypass when empty: define DISPATCH_BYPASS_EN.

`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE 2'd0
`endif

module dispatch_queue #(
   parameter int unsigned WIDTH        = 2,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned PAYLOAD_W    = 256,
   parameter int unsigned ROB_SIZE_LOG = 6
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [WIDTH-1:0]                in_valid,
   input  logic [WIDTH*PAYLOAD_W-1:0]      in_payload,
   output logic                            in_ready,
   input  logic [ROB_SIZE_LOG:0]           rob_free_cnt,
   input  logic                            enq_robidx_flag,
   input  logic [ROB_SIZE_LOG-1:0]         enq_robidx,
   input  logic [1:0]                      rob_state,
   output logic [WIDTH-1:0]                out_valid,
   input  logic [WIDTH-1:0]                out_ready,
   output logic [WIDTH*PAYLOAD_W-1:0]      out_payload,
   output logic [WIDTH-1:0]                out_robidx_flag,
   output logic [WIDTH*ROB_SIZE_LOG-1:0]   out_robidx,
   input  logic                            flush_valid,
   output logic [$clog2(DEPTH+1)-1:0]      occupancy
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH+1);
   localparam int unsigned LANE_W = $clog2(WIDTH+1);
   localparam int unsigned ROB_W  = ROB_SIZE_LOG;

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic [LANE_W-1:0]    enq_n;
   logic [LANE_W-1:0]    fire_n;
   logic [LANE_W-1:0]    skip_n;
   logic                 byp;
   logic                 rob_idle;
   logic                 fire_run;
   logic [ROB_W:0]       rob_sum;

   assign rob_idle  = (rob_state == `ROB_STATE_IDLE);
   assign in_ready  = ((32'(DEPTH) - 32'(count_q)) >= 32'(WIDTH)) & ~flush_valid;
   assign occupancy = count_q;

   // Bypass path is only live while the queue is empty.
   always_comb begin
      byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
      byp = (count_q == '0);
`endif
   end

   // Issue presentation, ROB stamping and leading-run fire count.
   always_comb begin
      out_valid       = '0;
      out_payload     = '0;
      out_robidx      = '0;
      out_robidx_flag = '0;
      fire_n          = '0;
      fire_run        = 1'b1;
      rob_sum         = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (byp) begin
            out_valid[k] = in_valid[k];
            out_payload[k*PAYLOAD_W +: PAYLOAD_W] = in_payload[k*PAYLOAD_W +: PAYLOAD_W];
         end else begin
            out_valid[k] = (32'(count_q) > 32'(k));
            out_payload[k*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PTR_W'(k)];
         end
         out_valid[k] = out_valid[k] & (32'(rob_free_cnt) > 32'(k)) & rob_idle & ~flush_valid;
         rob_sum = {1'b0, enq_robidx} + (ROB_W+1)'(k);
         out_robidx[k*ROB_W +: ROB_W] = rob_sum[ROB_W-1:0];
         out_robidx_flag[k] = enq_robidx_flag ^ rob_sum[ROB_W];
         fire_run = fire_run & out_valid[k] & out_ready[k];
         if (fire_run) fire_n = fire_n + LANE_W'(1);
      end
   end

   // Enqueue count; in_valid is thermometer so popcount is the lane span.
   always_comb begin
      enq_n = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (in_valid[k] && in_ready) enq_n = enq_n + LANE_W'(1);
      end
      skip_n = byp ? fire_n : '0;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(enq_n) - CNT_W'(fire_n);
      if (flush_valid) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (byp) begin
         tail_d = tail_q + PTR_W'(enq_n) - PTR_W'(fire_n);
      end else begin
         head_d = head_q + PTR_W'(fire_n);
         tail_d = tail_q + PTR_W'(enq_n);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; lanes already bypassed to issue are skipped.
   always_ff @(posedge clock) begin
      for (int k = 0; k < WIDTH; k++) begin
         if (in_ready && in_valid[k] && (32'(k) >= 32'(skip_n))) begin
            mem_q[tail_q + PTR_W'(k) - PTR_W'(skip_n)] <= in_payload[k*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue (WIDTH=2, DEPTH=4, ROB_SIZE_LOG=3).

module tb_dispatch_queue;

   localparam int unsigned WIDTH = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 16;
   localparam int unsigned RL    = 3;

   logic                  clock = 1'b0;
   logic                  reset_n;
   logic [WIDTH-1:0]      in_valid;
   logic [WIDTH*PW-1:0]   in_payload;
   logic                  in_ready;
   logic [RL:0]           rob_free_cnt;
   logic                  enq_robidx_flag;
   logic [RL-1:0]         enq_robidx;
   logic [1:0]            rob_state;
   logic [WIDTH-1:0]      out_valid;
   logic [WIDTH-1:0]      out_ready;
   logic [WIDTH*PW-1:0]   out_payload;
   logic [WIDTH-1:0]      out_robidx_flag;
   logic [WIDTH*RL-1:0]   out_robidx;
   logic                  flush_valid;
   logic [2:0]            occupancy;

   int tests_run    = 0;
   int tests_failed = 0;

   dispatch_queue #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .PAYLOAD_W(PW), .ROB_SIZE_LOG(RL)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_payload(in_payload), .in_ready(in_ready),
      .rob_free_cnt(rob_free_cnt), .enq_robidx_flag(enq_robidx_flag),
      .enq_robidx(enq_robidx), .rob_state(rob_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
      .out_robidx_flag(out_robidx_flag), .out_robidx(out_robidx),
      .flush_valid(flush_valid), .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n         = 1'b0;
      in_valid        = '0;
      in_payload      = '0;
      rob_free_cnt    = 4'd8;
      enq_robidx_flag = 1'b0;
      enq_robidx      = '0;
      rob_state       = 2'd0;
      out_ready       = '0;
      flush_valid     = 1'b0;
      #3;
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_ovalid", 64'(out_valid), 64'd0);
      #9 reset_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      tick();

      // Basic enqueue of A,B then presentation with ROB stamp
      in_valid   = 2'b11;
      in_payload = {16'hB0B0, 16'hA0A0};
      #1;
`ifdef DISPATCH_BYPASS_EN
      chk("byp_ovalid", 64'(out_valid), 64'd3);
`else
      chk("enq_cycle_ovalid", 64'(out_valid), 64'd0);
`endif
      tick();
      in_valid = '0;
      #1;
      chk("t1_ovalid", 64'(out_valid), 64'd3);
      chk("t1_lane0", 64'(out_payload[15:0]), 64'hA0A0);
      chk("t1_lane1", 64'(out_payload[31:16]), 64'hB0B0);
      chk("t1_robidx", 64'(out_robidx), 64'h08);
      chk("t1_flag", 64'(out_robidx_flag), 64'd0);
      chk("t1_occ", 64'(occupancy), 64'd2);

      // ROB index wrap across lanes
      enq_robidx = 3'd7;
      #1;
      chk("wrap_robidx", 64'(out_robidx), 64'h07);
      chk("wrap_flag", 64'(out_robidx_flag), 64'b10);
      enq_robidx = 3'd0;

      // Non-leading ready fires nothing; then only lane 0 fires
      out_ready = 2'b10;
      tick();
      chk("nofire_occ", 64'(occupancy), 64'd2);
      chk("nofire_lane0", 64'(out_payload[15:0]), 64'hA0A0);
      out_ready = 2'b01;
      tick();
      out_ready = '0;
      #1;
      chk("fire1_occ", 64'(occupancy), 64'd1);
      chk("fire1_ovalid", 64'(out_valid), 64'b01);
      chk("fire1_lane0", 64'(out_payload[15:0]), 64'hB0B0);
      out_ready = 2'b01;
      tick();
      out_ready = '0;
      #1;
      chk("drain_occ", 64'(occupancy), 64'd0);
      chk("drain_ovalid", 64'(out_valid), 64'd0);

      // Fill to DEPTH with issue stalled
      in_valid   = 2'b11;
      in_payload = {16'hD0D0, 16'hC0C0};
      tick();
      chk("fill2_ready", 64'(in_ready), 64'd1);
      in_payload = {16'hF0F0, 16'hE0E0};
      tick();
      in_valid = '0;
      #1;
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_occ", 64'(occupancy), 64'd4);
      rob_free_cnt = 4'd1;
      #1;
      chk("robfree1_ovalid", 64'(out_valid), 64'b01);
      rob_free_cnt = 4'd0;
      #1;
      chk("robfree0_ovalid", 64'(out_valid), 64'd0);
      rob_free_cnt = 4'd8;
      out_ready = 2'b01;
      tick();
      out_ready = '0;
      #1;
      chk("cnt3_ready", 64'(in_ready), 64'd0);
      chk("cnt3_occ", 64'(occupancy), 64'd3);
      chk("cnt3_lane0", 64'(out_payload[15:0]), 64'hD0D0);

      // Conservative full: no enqueue even while two lanes dequeue
      in_valid   = 2'b11;
      in_payload = {16'h9999, 16'h8888};
      out_ready  = 2'b11;
      #1;
      chk("deq_full_ready", 64'(in_ready), 64'd0);
      tick();
      in_valid  = '0;
      out_ready = '0;
      #1;
      chk("deq2_occ", 64'(occupancy), 64'd1);
      chk("deq2_lane0", 64'(out_payload[15:0]), 64'hF0F0);

      // Build three entries then flush alongside a new enqueue
      in_valid   = 2'b11;
      in_payload = {16'h1111, 16'h0101};
      tick();
      chk("pre_flush_occ", 64'(occupancy), 64'd3);
      flush_valid = 1'b1;
      in_payload  = {16'h7777, 16'h6666};
      out_ready   = 2'b11;
      #1;
      chk("flush_ready", 64'(in_ready), 64'd0);
      chk("flush_ovalid", 64'(out_valid), 64'd0);
      tick();
      flush_valid = 1'b0;
      in_valid    = '0;
      out_ready   = '0;
      #1;
      chk("post_flush_occ", 64'(occupancy), 64'd0);
      chk("post_flush_ovalid", 64'(out_valid), 64'd0);
      in_valid   = 2'b11;
      in_payload = {16'h2B2B, 16'h2A2A};
      tick();
      in_valid = '0;
      #1;
      chk("refill_lane0", 64'(out_payload[15:0]), 64'h2A2A);
      chk("refill_lane1", 64'(out_payload[31:16]), 64'h2B2B);
      chk("refill_occ", 64'(occupancy), 64'd2);

      // Non-idle ROB stalls all lanes
      rob_state = 2'd1;
      out_ready = 2'b11;
      #1;
      chk("robbusy_ovalid", 64'(out_valid), 64'd0);
      tick();
      chk("robbusy_occ", 64'(occupancy), 64'd2);
      out_ready = '0;
      rob_state = 2'd0;
      #1;
      chk("robidle_ovalid", 64'(out_valid), 64'd3);

      // Async reset mid-stream clears before any clock edge
      reset_n = 1'b0;
      #1;
      chk("async_occ", 64'(occupancy), 64'd0);
      chk("async_ovalid", 64'(out_valid), 64'd0);
      #1 reset_n = 1'b1;
      tick();
      chk("after_rst_ready", 64'(in_ready), 64'd1);
      chk("after_rst_ovalid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
